dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the MEM stage of the five-stage MIPS pipeline. It holds the data memory array and services one load or store at a time from the MEM stage over a valid/ready request and one-cycle response handshake. It supports word and byte accesses and inserts a programmable number of wait states. While an access is outstanding it drives `MEM_stall`, and the pipeline freezes IF through MEM until the response cycle.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; power of two, 16 to 65536.
- `WAIT_CYCLES`, 2: wait states inserted between acceptance and response; legal range 0 to 15.

Ports:
- `Clk` input 1: single clock; all state updates on the rising edge.
- `Rst` input 1: synchronous, active-high reset.
- `Req_valid` input 1: MEM stage presents a request; held stable until the response cycle.
- `Req_write` input 1: 1 = store, 0 = load.
- `Req_byte` input 1: 1 = byte access (lb/sb), 0 = word access (lw/sw).
- `Req_adrs` input 32: byte address (ALU result, `Adrs_MEM`).
- `Req_wdata` input 32: store data; for a byte store, bits [7:0] are used.
- `Req_ready` output 1: responder can accept in this cycle.
- `Resp_valid` output 1: one-cycle pulse marking request completion.
- `Resp_rdata` output 32: load data, valid while `Resp_valid`=1.
- `Resp_error` output 1: access faulted, valid while `Resp_valid`=1.
- `MEM_stall` output 1: freeze pipeline stages IF through MEM.

## Operation
- The state machine has three states: IDLE, WAIT and RESP.
- **IDLE**
  - `Req_ready`=1.
  - `Req_valid`=1 accepts the request and latches the address, data, write and byte fields.
  - It then moves to WAIT, or to RESP if `WAIT_CYCLES`=0.
- **WAIT**
  - A 4-bit counter is loaded with `WAIT_CYCLES`-1 on acceptance and decrements each cycle.
  - At 0 the block performs the access and moves to RESP.
  - `Req_valid` is ignored in this state.
- **RESP**
  - `Resp_valid`=1 for exactly one cycle, then the block returns to IDLE.
  - A request presented in the following cycle is a new request; there is no back-to-back acceptance in RESP.
- **Access, performed on the edge entering RESP**
  - Word index is `Req_adrs[log2(DEPTH_WORDS)+1:2]`.
  - Byte lane ordering is big-endian: byte offset 0 maps to bits [31:24] and offset 3 maps to bits [7:0].
  - Word load: `Resp_rdata` = array word.
  - Byte load: the selected byte is sign-extended to 32 bits.
  - Word store: the whole word is written.
  - Byte store: only the selected lane is written with `Req_wdata[7:0]`; the other lanes are unchanged.
  - For stores, `Resp_rdata` = 0.
- **Stall**
  - `MEM_stall` = (IDLE and `Req_valid`) or WAIT.
  - `MEM_stall` is 0 in RESP, so the instruction advances on the edge ending RESP.
- **Reset**
  - `Rst`=1 forces IDLE and clears the counter, `Resp_valid`, `Resp_rdata` and `Resp_error`.
  - `Req_ready`=0 and `MEM_stall`=0 while `Rst`=1; both are gated by `Rst`.
  - Array contents are not reset.
  - Reset during WAIT aborts the request, and a pending store is never committed.
  - Reset during RESP: the already-committed store remains and the response is dropped.

## Timing
- A request accepted at the edge ending cycle t has `Resp_valid` in cycle t+`WAIT_CYCLES`+1.
- `MEM_stall` is high for `WAIT_CYCLES`+1 cycles per access.
- With `WAIT_CYCLES`=0, a one-cycle stall occurs and the response arrives in the next cycle.
- Throughput is one access per `WAIT_CYCLES`+2 cycles when requests are continuous.
- `Resp_rdata` and `Resp_error` are registered.
- `Req_ready` and `MEM_stall` are combinational from state, `Req_valid` and `Rst` only; there is no path from the data inputs.
- A load issued the cycle after a store to the same word returns the new data, because the store commits before the load's access edge.

## Configuration
- **`DMEM_ERROR_CHECK_EN` defined:**
  - Misalignment: a word access with `Req_adrs[1:0]`≠0 faults.
  - Out of range: `Req_adrs` ≥ 4·`DEPTH_WORDS` faults.
  - A fault gives `Resp_error`=1 and `Resp_rdata`=0, with no array write.
  - Latency is unchanged.
- **`DMEM_ERROR_CHECK_EN` undefined:**
  - `Resp_error` is tied to 0.
  - Word accesses ignore `Req_adrs[1:0]`.
  - Addresses wrap modulo 4·`DEPTH_WORDS`.

## Test plan
- Word store then load, `WAIT_CYCLES`=2: sw 0xDEADBEEF to 0x40, then lw 0x40 gives `Resp_rdata`=0xDEADBEEF. Each access shows `MEM_stall` high for exactly 3 cycles and `Resp_valid` for 1 cycle.
- Byte lanes, with word 0x11223344 at 0x80:
  - lb 0x81 gives 0x00000022.
  - sb 0xF0 to 0x83, then lw 0x80 gives 0x112233F0.
  - lb 0x83 gives 0xFFFFFFF0.
- `WAIT_CYCLES`=0 with `Req_valid` held over 4 loads: a response every 2nd cycle, `Req_ready` alternating 1/0, and no request lost or duplicated.
- With the error check enabled:
  - lw 0x42 gives `Resp_error`=1 and `Resp_rdata`=0, and the word at 0x40 is unchanged.
  - sw to 4·`DEPTH_WORDS` gives `Resp_error`=1.
  - With the macro undefined, the same sw overwrites word 0.
- Reset mid-operation: sw 0x12345678 to 0x10, with `Rst` asserted in the first WAIT cycle, then lw 0x10 gives the old value. All outputs are 0 during reset and `Req_ready`=1 in the first cycle after release.

Source files
------------

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle for dmem_responder.
// The master is the MEM stage; the slave is the data-memory responder.
interface dmem_responder_if;
  logic        Req_valid;
  logic        Req_write;
  logic        Req_byte;
  logic [31:0] Req_adrs;
  logic [31:0] Req_wdata;
  logic        Req_ready;
  logic        Resp_valid;
  logic [31:0] Resp_rdata;
  logic        Resp_error;
  logic        MEM_stall;

  modport master (
    output Req_valid, Req_write, Req_byte, Req_adrs, Req_wdata,
    input  Req_ready, Resp_valid, Resp_rdata, Resp_error, MEM_stall
  );

  modport slave (
    input  Req_valid, Req_write, Req_byte, Req_adrs, Req_wdata,
    output Req_ready, Resp_valid, Resp_rdata, Resp_error, MEM_stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS MEM stage: word/byte big-endian loads and stores
// with WAIT_CYCLES wait states. Define DMEM_ERROR_CHECK_EN for misalign/range faults.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic             Clk,
  input logic             Rst,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic        byte_q, byte_d;
  logic [31:0] adrs_q, adrs_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic          acc_write, acc_byte;
  logic [31:0]   acc_adrs, acc_wdata;
  logic [AW-1:0] acc_idx;
  logic [1:0]    acc_off;
  logic [4:0]    lane_lsb;
  logic [31:0]   rd_word, wr_word;
  logic [7:0]    rd_byte;
  logic          acc_fault;
  logic          do_access;
  logic          mem_we;

  // With zero wait states the access happens on the accepting edge, so the
  // live request fields are used instead of the not-yet-latched copies.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_write = bus.Req_write;
      acc_byte  = bus.Req_byte;
      acc_adrs  = bus.Req_adrs;
      acc_wdata = bus.Req_wdata;
    end else begin
      acc_write = write_q;
      acc_byte  = byte_q;
      acc_adrs  = adrs_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_idx  = acc_adrs[AW+1:2];
  assign acc_off  = acc_adrs[1:0];
  assign lane_lsb = {~acc_off, 3'b000};
  assign rd_word  = mem_q[acc_idx];
  assign rd_byte  = rd_word[lane_lsb +: 8];

`ifdef DMEM_ERROR_CHECK_EN
  assign acc_fault = (!acc_byte && (acc_off != 2'b00)) || (acc_adrs[31:AW+2] != '0);
`else
  logic unused_adrs_hi;
  assign unused_adrs_hi = ^acc_adrs[31:AW+2];
  assign acc_fault      = 1'b0;
`endif

  always_comb begin
    wr_word = rd_word;
    if (acc_byte) begin
      wr_word[lane_lsb +: 8] = acc_wdata[7:0];
    end else begin
      wr_word = acc_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    byte_d       = byte_q;
    adrs_d       = adrs_q;
    wdata_d      = wdata_q;
    do_access    = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_error_d = 1'b0;
    mem_we       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.Req_valid) begin
          write_d = bus.Req_write;
          byte_d  = bus.Req_byte;
          adrs_d  = bus.Req_adrs;
          wdata_d = bus.Req_wdata;
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = ST_RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          do_access = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_access) begin
      resp_valid_d = 1'b1;
      resp_error_d = acc_fault;
      mem_we       = acc_write && !acc_fault;
      if (!acc_write && !acc_fault) begin
        resp_rdata_d = acc_byte ? {{24{rd_byte[7]}}, rd_byte} : rd_word;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      byte_q       <= 1'b0;
      adrs_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      byte_q       <= byte_d;
      adrs_q       <= adrs_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  // Array contents survive reset; a store whose commit edge sees Rst is dropped.
  always_ff @(posedge Clk) begin
    if (!Rst && mem_we) begin
      mem_q[acc_idx] <= wr_word;
    end
  end

  assign bus.Req_ready  = !Rst && (state_q == ST_IDLE);
  assign bus.MEM_stall  = !Rst && (((state_q == ST_IDLE) && bus.Req_valid) || (state_q == ST_WAIT));
  assign bus.Resp_valid = resp_valid_q;
  assign bus.Resp_rdata = resp_rdata_q;
  assign bus.Resp_error = resp_error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: a WAIT_CYCLES=2 instance checked against a
// transaction-level memory model, plus a WAIT_CYCLES=0 instance for continuous streaming.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned WA    = 2;
`ifdef DMEM_ERROR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if a_if ();
  dmem_responder_if b_if ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WA)) u_dut_a (
    .Clk (clk),
    .Rst (rst),
    .bus (a_if)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_b (
    .Clk (clk),
    .Rst (rst),
    .bus (b_if)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] ref_a [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory seen as an array of big-endian words; updates the model on stores.
  task automatic model(input bit wr, input bit by, input logic [31:0] adr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
    int unsigned idx;
    int unsigned sh;
    logic [31:0] b;
    idx = (adr / 4) % DEPTH;
    sh  = 8 * (3 - (adr % 4));
    err = ERR_EN && ((!by && (adr % 4) != 0) || (adr >= 4 * DEPTH));
    rd  = '0;
    if (!err) begin
      if (wr) begin
        if (by) ref_a[idx] = (ref_a[idx] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
        else    ref_a[idx] = wd;
      end else if (by) begin
        b  = (ref_a[idx] >> sh) & 32'hFF;
        rd = (b < 32'd128) ? b : b + 32'hFFFFFF00;
      end else begin
        rd = ref_a[idx];
      end
    end
  endtask

  task automatic access(input bit wr, input bit by, input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          stall_n = 0;
    int          lat     = -1;
    model(wr, by, adr, wd, exp_rd, exp_err);
    @(negedge clk);
    a_if.Req_valid = 1'b1;
    a_if.Req_write = wr;
    a_if.Req_byte  = by;
    a_if.Req_adrs  = adr;
    a_if.Req_wdata = wd;
    #1;
    check_eq("ready_idle", a_if.Req_ready, 1);
    check_eq("no_resp_idle", a_if.Resp_valid, 0);
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (a_if.MEM_stall) stall_n++;
      if (a_if.Resp_valid) begin
        lat = c;
        check_eq($sformatf("rdata wr=%0b by=%0b a=%h", wr, by, adr), a_if.Resp_rdata, exp_rd);
        check_eq($sformatf("error wr=%0b by=%0b a=%h", wr, by, adr), a_if.Resp_error, exp_err);
        break;
      end
    end
    check_eq("latency", 32'(lat), WA + 1);
    check_eq("stall_cycles", 32'(stall_n), WA + 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, a_if.Req_ready, 0);
    check_eq({tag, "_stall"}, a_if.MEM_stall, 0);
    check_eq({tag, "_rvalid"}, a_if.Resp_valid, 0);
    check_eq({tag, "_rdata"}, a_if.Resp_rdata, 0);
    check_eq({tag, "_rerr"}, a_if.Resp_error, 0);
    check_eq({tag, "_b_ready"}, b_if.Req_ready, 0);
    check_eq({tag, "_b_stall"}, b_if.MEM_stall, 0);
  endtask

  initial begin
    logic [31:0] bdat [4];
    int unsigned resp_n;
    logic [31:0] adr;

    rst = 1'b1;
    a_if.Req_valid = 1'b1; a_if.Req_write = 1'b0; a_if.Req_byte = 1'b0;
    a_if.Req_adrs  = '0;   a_if.Req_wdata = '0;
    b_if.Req_valid = 1'b1; b_if.Req_write = 1'b0; b_if.Req_byte = 1'b0;
    b_if.Req_adrs  = '0;   b_if.Req_wdata = '0;
    repeat (2) begin
      @(negedge clk);
      #1;
      check_all_zero("reset");
    end
    @(negedge clk);
    rst = 1'b0;
    a_if.Req_valid = 1'b0;
    b_if.Req_valid = 1'b0;
    #1;
    check_eq("ready_after_reset", a_if.Req_ready, 1);
    check_eq("b_ready_after_reset", b_if.Req_ready, 1);

    for (int unsigned i = 0; i < DEPTH; i++) access(1'b1, 1'b0, 32'(i * 4), $urandom);

    access(1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
    access(1'b0, 1'b0, 32'h40, '0);
    access(1'b1, 1'b0, 32'h80, 32'h11223344);
    access(1'b0, 1'b1, 32'h81, '0);
    access(1'b1, 1'b1, 32'h83, 32'hA5A5A5F0);
    access(1'b0, 1'b0, 32'h80, '0);
    access(1'b0, 1'b1, 32'h83, '0);
    access(1'b0, 1'b0, 32'h42, '0);
    access(1'b0, 1'b0, 32'h40, '0);
    access(1'b1, 1'b0, 32'(4 * DEPTH), 32'hCAFEF00D);
    access(1'b0, 1'b0, 32'h0, '0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) adr = 32'($urandom_range(0, 1023));
      else                           adr = 32'($urandom_range(0, 4 * DEPTH - 1));
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), adr, $urandom);
    end

    // Store aborted by reset in its first wait cycle must not commit.
    @(negedge clk);
    a_if.Req_valid = 1'b1; a_if.Req_write = 1'b1; a_if.Req_byte = 1'b0;
    a_if.Req_adrs  = 32'h10; a_if.Req_wdata = 32'h12345678;
    #1;
    check_eq("abort_accept_ready", a_if.Req_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    a_if.Req_valid = 1'b0;
    #1;
    check_all_zero("midreset1");
    @(negedge clk);
    #1;
    check_all_zero("midreset2");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("ready_after_midreset", a_if.Req_ready, 1);
    check_eq("rvalid_after_midreset", a_if.Resp_valid, 0);
    access(1'b0, 1'b0, 32'h10, '0);
    access(1'b0, 1'b0, 32'h13, '0);

    @(negedge clk);
    a_if.Req_valid = 1'b0;

    // Zero-wait instance: Req_valid held across 4 stores then 4 loads.
    for (int k = 0; k < 4; k++) bdat[k] = $urandom;
    resp_n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      b_if.Req_valid = 1'b1;
      b_if.Req_write = (k < 4);
      b_if.Req_byte  = 1'b0;
      b_if.Req_adrs  = 32'(32'h20 + 4 * (k % 4));
      b_if.Req_wdata = bdat[k % 4];
      #1;
      check_eq("b_accept_ready", b_if.Req_ready, 1);
      check_eq("b_accept_stall", b_if.MEM_stall, 1);
      check_eq("b_accept_rvalid", b_if.Resp_valid, 0);
      @(negedge clk);
      #1;
      check_eq("b_resp_ready", b_if.Req_ready, 0);
      check_eq("b_resp_stall", b_if.MEM_stall, 0);
      check_eq("b_resp_rvalid", b_if.Resp_valid, 1);
      check_eq($sformatf("b_rdata_%0d", k), b_if.Resp_rdata, (k < 4) ? 32'h0 : bdat[k % 4]);
      check_eq("b_rerr", b_if.Resp_error, 0);
      if (b_if.Resp_valid) resp_n++;
    end
    @(negedge clk);
    b_if.Req_valid = 1'b0;
    #1;
    check_eq("b_rvalid_after", b_if.Resp_valid, 0);
    check_eq("b_resp_count", resp_n, 8);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
